instr_encoder: RTL and testbench

Streaming MIPS-subset instruction encoder and instruction-memory loader; it is the inverse of the control decoder.
- Accepts one symbolic instruction per handshake: kind code plus rs/rt/rd/imm16/target fields.
- Packs each into the 32-bit word format the control decoder expects.
- Buffers words in a 2-entry FIFO and writes them to consecutive instruction-memory word addresses.
- Used by the test/boot path to load programs into the single-cycle/pipelined CPU.

---
 rtl/instr_encoder.sv | 154 +++++++++++++++
 tb/tb_instr_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Streaming MIPS-subset instruction encoder feeding instruction memory through a 2-entry FIFO.
// Optional macro ENC_FIELD_CHECK_EN rejects writes to register 0 for ADD/SUB/SLT/LW/XORI.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0][31:0]  mem_q, mem_d;
    logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept, push, pop;
    logic [CW-1:0] total_q;

    // Bit 32 flags a legal kind; unused fields stay zero.
    function automatic logic [32:0] encode(input logic [3:0] kind, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [15:0] imm, input logic [25:0] tgt);
        logic [31:0] w;
        logic        ok;
        w  = 32'h0;
        ok = 1'b1;
        case (kind)
            4'd0: w = 32'h0;
            4'd1: w = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
            4'd2: w = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
            4'd3: w = {6'b000000, rs, rt, rd, 5'd0, 6'b101010};
            4'd4: w = {6'b000000, rs, 5'd0, 5'd0, 5'd0, 6'b001000};
            4'd5: w = {6'b100011, rs, rt, imm};
            4'd6: w = {6'b101011, rs, rt, imm};
            4'd7: w = {6'b000101, rs, rt, imm};
            4'd8: w = {6'b000010, tgt};
            4'd9: w = {6'b001110, rs, rt, imm};
            default: ok = 1'b0;
        endcase
`ifdef ENC_FIELD_CHECK_EN
        if ((kind == 4'd1 || kind == 4'd2 || kind == 4'd3) && rd == 5'd0) ok = 1'b0;
        if ((kind == 4'd5 || kind == 4'd9) && rt == 5'd0) ok = 1'b0;
`endif
        return {ok, w};
    endfunction

    always_comb begin
        {enc_legal, enc_word} = encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
    end

    assign total_q  = count_q + CW'(occ_q);
    assign in_ready = (state_q == S_RUN) && (occ_q != 2'd2) && (total_q < MAX_C);
    assign wr_en    = (state_q == S_RUN || state_q == S_DRAIN) && (occ_q != 2'd0);
    assign wr_data  = mem_q[rd_ptr_q];
    assign wr_addr  = wr_addr_q;
    assign count    = count_q;
    assign done     = (state_q == S_DONE);
    assign err      = err_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && enc_legal;
    assign pop    = wr_en && wr_ready;

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        occ_d     = occ_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        err_d     = err_q;
        if (start) begin
            // Restart wins over flush and drops any same-cycle handshake.
            state_d   = S_RUN;
            wr_addr_d = start_addr;
            count_d   = '0;
            occ_d     = 2'd0;
            rd_ptr_d  = 1'b0;
            wr_ptr_d  = 1'b0;
            err_d     = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d  = ~rd_ptr_q;
                wr_addr_d = wr_addr_q + 1'b1;
                count_d   = count_q + 1'b1;
            end
            if (push) begin
                mem_d[wr_ptr_q] = enc_word;
                wr_ptr_d        = ~wr_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
            if (accept && !enc_legal) err_d = 1'b1;
            case (state_q)
                S_RUN:   if (flush || (count_d + CW'(occ_d)) >= MAX_C) state_d = S_DRAIN;
                S_DRAIN: if (occ_d == 2'd0) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mem_q     <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
            wr_addr_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            occ_q     <= occ_d;
            wr_addr_q <= wr_addr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (MAX_WORDS=3) with hand-computed encodings.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        reset, start, flush, in_valid, wr_ready;
    logic [7:0]  start_addr;
    logic        in_ready, wr_en, done, err;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [8:0]  count;

    int checks = 0;
    int failures = 0;
    logic [7:0]  log_a[$];
    logic [31:0] log_d[$];

    instr_encoder #(.ADDR_W(8), .MAX_WORDS(3)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en && wr_ready) begin
            log_a.push_back(wr_addr);
            log_d.push_back(wr_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] a);
        start = 1'b1; start_addr = a;
        step();
        start = 1'b0;
        log_a.delete(); log_d.delete();
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        int n;
        in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        chk("send_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 30) begin step(); n++; end
        chk("wait_done", 32'(done), 32'd1);
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [7:0] a, input logic [31:0] d);
        if (log_a.size() > idx) begin
            chk({tag, "_addr"}, 32'(log_a[idx]), 32'(a));
            chk({tag, "_data"}, log_d[idx], d);
        end else begin
            chk({tag, "_present"}, 32'(log_a.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
        start_addr = '0; in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; in_target = '0;
        step(); step();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", wr_data, 0);
        reset = 1'b0;
        step();

        // ADD with one-cycle latency
        wr_ready = 1'b1;
        do_start(8'h10);
        chk("t1_ready", 32'(in_ready), 1);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        chk("t1_wr_en", 32'(wr_en), 1);
        chk("t1_addr", 32'(wr_addr), 32'h10);
        chk("t1_data", wr_data, 32'h00221820);
        chk("t1_count0", 32'(count), 0);
        step();
        chk("t1_count1", 32'(count), 1);
        chk("t1_idle_wr", 32'(wr_en), 0);

        // LW then BNE
        wr_ready = 1'b0;
        do_start(8'h10);
        send(4'd5, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0);
        send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'h0);
        chk("t2_full", 32'(in_ready), 0);
        chk("t2_lw_data", wr_data, 32'h8C850010);
        chk("t2_lw_addr", 32'(wr_addr), 32'h10);
        wr_ready = 1'b1;
        step();
        chk("t2_bne_data", wr_data, 32'h1422FFFE);
        chk("t2_bne_addr", 32'(wr_addr), 32'h11);
        chk("t2_count1", 32'(count), 1);
        step();
        chk("t2_count2", 32'(count), 2);

        // J and XORI under back-pressure
        wr_ready = 1'b0;
        do_start(8'h20);
        send(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
        send(4'd9, 5'd0, 5'd8, 5'd0, 16'hFFFF, 26'h0);
        chk("t3_full", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_data", wr_data, 32'h08000040);
            chk("t3_hold_en", 32'(wr_en), 1);
        end
        chk("t3_hold_addr", 32'(wr_addr), 32'h20);
        wr_ready = 1'b1;
        step();
        chk("t3_xori_data", wr_data, 32'h3808FFFF);
        chk("t3_xori_addr", 32'(wr_addr), 32'h21);

        // Address wrap and MAX_WORDS limit
        do_start(8'hFF);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h55);
        send(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        send(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        chk("t4_stop", 32'(in_ready), 0);
        wait_done();
        chk("t4_count", 32'(count), 3);
        chk("t4_nwr", 32'(log_a.size()), 3);
        chk_log("t4_w0", 0, 8'hFF, 32'h0);
        chk_log("t4_w1", 1, 8'h00, 32'h0);
        chk_log("t4_w2", 2, 8'h01, 32'h0);

        // Illegal kind then flush
        do_start(8'h40);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(4'hC, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        chk("t5_err", 32'(err), 1);
        send(4'd1, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_done();
        chk("t5_nwr", 32'(log_a.size()), 2);
        chk_log("t5_w0", 0, 8'h40, 32'h00221820);
        chk_log("t5_w1", 1, 8'h41, 32'h00E84820);
        chk("t5_count", 32'(count), 2);
        chk("t5_err_sticky", 32'(err), 1);

        // Reset with two words queued
        wr_ready = 1'b0;
        do_start(8'h50);
        chk("t6_err_clr", 32'(err), 0);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        chk("t6_queued", 32'(wr_en), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_wr_en", 32'(wr_en), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_ready", 32'(in_ready), 0);

        // Remaining encodings
        wr_ready = 1'b1;
        do_start(8'h60);
        send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(4'd4, 5'd31, 5'd5, 5'd6, 16'h7777, 26'h0);
        wait_done();
        chk_log("t7_sub", 0, 8'h60, 32'h00221822);
        chk_log("t7_slt", 1, 8'h61, 32'h0022182A);
        chk_log("t7_jr", 2, 8'h62, 32'h03E00008);
        do_start(8'h70);
        send(4'd6, 5'd2, 5'd3, 5'd9, 16'h0004, 26'h0);
        send(4'd0, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF);
        send(4'd8, 5'd1, 5'd1, 5'd1, 16'h1, 26'h3FFFFFF);
        wait_done();
        chk_log("t7_sw", 0, 8'h70, 32'hAC430004);
        chk_log("t7_nop", 1, 8'h71, 32'h0);
        chk_log("t7_j", 2, 8'h72, 32'h0BFFFFFF);

        // Destination register 0
        do_start(8'h80);
        send(4'd1, 5'd1, 5'd2, 5'd0, 16'h0, 26'h0);
        send(4'd9, 5'd1, 5'd0, 5'd0, 16'h0005, 26'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_done();
`ifdef ENC_FIELD_CHECK_EN
        chk("t8_nwr", 32'(log_a.size()), 0);
        chk("t8_err", 32'(err), 1);
`else
        chk("t8_nwr", 32'(log_a.size()), 2);
        chk_log("t8_add", 0, 8'h80, 32'h00220020);
        chk_log("t8_xori", 1, 8'h81, 32'h38200005);
        chk("t8_err", 32'(err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
